// File: rtl/io_ctrl_if.sv
// CPU-side I/O bus between the address mux and the io_ctrl responder.
// Master drives address/strobe/write data, slave returns read data.
interface io_ctrl_if;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  io_di;
  logic [7:0]  io_do;

  modport master (
    output addr,
    output we,
    output io_di,
    input  io_do
  );

  modport slave (
    input  addr,
    input  we,
    input  io_di,
    output io_do
  );
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped I/O responder: LED register, synchronized switches and
// a prescaled 8-bit down-counter timer with expiry flag and interrupt.
module io_ctrl #(
  parameter logic [15:0] RAM_BASE = 16'h8000
) (
  input  logic           clk,
  input  logic           rst,
  io_ctrl_if.slave       bus,
  input  logic [7:0]     sw,
  output logic [7:0]     led,
  output logic           irq
);

  logic [7:0] led_q, led_d;
  logic [7:0] sw1_q, sw2_q;
  logic       en_q, en_d;
  logic       auto_q, auto_d;
  logic       ie_q, ie_d;
  logic       flag_q, flag_d;
  logic [7:0] reload_q, reload_d;
  logic [7:0] count_q, count_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] presc_q, presc_d;

  logic       sel;
  logic       wr;
  logic [2:0] idx;
  logic       ctrl_wr;
  logic       stop;
  logic       start;
  logic       tick;
  logic       tick_v;
  logic       expire;

  assign sel = bus.addr < RAM_BASE;
  assign idx = bus.addr[2:0];
  assign wr  = bus.we && sel;

  always_comb begin
    led_d    = led_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    flag_d   = flag_q;
    reload_d = reload_q;
    count_d  = count_q;
    pre_d    = pre_q;
    presc_d  = presc_q;

    ctrl_wr = wr && (idx == 3'd2);
    stop    = ctrl_wr && !bus.io_di[0];
    start   = ctrl_wr && bus.io_di[0] && !en_q;
    tick    = en_q && (pre_q == presc_q);
    // a CTRL write that clears en swallows a coincident tick
    tick_v  = tick && !stop;
    expire  = tick_v && (count_q == 8'd0);

    if (en_q && !stop) begin
      pre_d = tick ? 8'd0 : pre_q + 8'd1;
    end

    if (tick_v) begin
      if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end else if (auto_q) begin
        count_d = reload_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (expire) begin
      flag_d = 1'b1;
    end

    if (ctrl_wr) begin
      auto_d = bus.io_di[1];
      ie_d   = bus.io_di[2];
      if (bus.io_di[7] && !expire) begin
        flag_d = 1'b0;
      end
      if (stop) begin
        en_d = 1'b0;
      end
      if (start) begin
        en_d    = 1'b1;
        count_d = reload_q;
        pre_d   = 8'd0;
      end
    end

    if (wr && (idx == 3'd0)) begin
      led_d = bus.io_di;
    end
    if (wr && (idx == 3'd3)) begin
      reload_d = bus.io_di;
    end
    if (wr && (idx == 3'd5)) begin
      presc_d = bus.io_di;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      sw1_q    <= '0;
      sw2_q    <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      flag_q   <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
      pre_q    <= '0;
      presc_q  <= '0;
    end else begin
      led_q    <= led_d;
      sw1_q    <= sw;
      sw2_q    <= sw1_q;
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      flag_q   <= flag_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      presc_q  <= presc_d;
    end
  end

  always_comb begin
    bus.io_do = 8'h00;
    case (idx)
      3'd0:    bus.io_do = led_q;
      3'd1:    bus.io_do = sw2_q;
      3'd2:    bus.io_do = {flag_q, 4'b0000, ie_q, auto_q, en_q};
      3'd3:    bus.io_do = reload_q;
      3'd4:    bus.io_do = count_q;
      3'd5:    bus.io_do = presc_q;
      default: bus.io_do = 8'h00;
    endcase
  end

  assign led = led_q;
  assign irq = flag_q & ie_q;

endmodule
